// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART byte transmitter and receiver on one link.
//   - Baud_sel codes and the matching bit-period end values for a 50 MHz clock
//     (bit period = BAUD_END + 1 cycles).
//   - Receiver FSM state encoding.
//   - Helpers: Baud_sel -> BAUD_END lookup, 2-of-3 majority vote.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  // Baud_sel codes; 5..7 are unused and fall back to 9600.
  localparam logic [2:0] BAUD_SEL_9600   = 3'd0;
  localparam logic [2:0] BAUD_SEL_19200  = 3'd1;
  localparam logic [2:0] BAUD_SEL_38400  = 3'd2;
  localparam logic [2:0] BAUD_SEL_57600  = 3'd3;
  localparam logic [2:0] BAUD_SEL_115200 = 3'd4;

  // Last count value of one bit period at 50 MHz.
  localparam logic [15:0] BAUD_END_9600   = 16'd5207;
  localparam logic [15:0] BAUD_END_19200  = 16'd2603;
  localparam logic [15:0] BAUD_END_38400  = 16'd1301;
  localparam logic [15:0] BAUD_END_57600  = 16'd867;
  localparam logic [15:0] BAUD_END_115200 = 16'd433;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  function automatic logic [15:0] baud_end_f(input logic [2:0] sel);
    logic [15:0] r;
    case (sel)
      BAUD_SEL_9600:   r = BAUD_END_9600;
      BAUD_SEL_19200:  r = BAUD_END_19200;
      BAUD_SEL_38400:  r = BAUD_END_38400;
      BAUD_SEL_57600:  r = BAUD_END_57600;
      BAUD_SEL_115200: r = BAUD_END_115200;
      default:         r = BAUD_END_9600;
    endcase
    return r;
  endfunction

  function automatic logic maj3_f(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// SYNC_STAGES-deep synchronizer for an asynchronous serial line plus a
// falling-edge detector on the synchronized value. Flops reset to 1 (idle
// line level) so leaving reset never looks like a start edge.
// SYNC_STAGES must be at least 2.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   rx_i     asynchronous serial input
//   rx_s_o   synchronized line value
//   fall_o   1 for one cycle when rx_s_o goes 1 -> 0
// -----------------------------------------------------------------------------
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s_o = sync_q[SYNC_STAGES-1];
  assign fall_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART byte receiver (LSB first, idle-high line), 50 MHz clock.
// A synchronized falling edge starts a frame; the start bit is re-checked at
// mid-bit to reject glitches, then data and stop bits are sampled one full bit
// period apart. A good stop bit publishes the byte with a one-cycle Rx_done; a
// low stop bit gives a one-cycle Frame_err and the receiver waits for the line
// to return high before re-arming.
//
// Optional build macro UART_RX_MAJORITY_EN: every sample is the 2-of-3
// majority of rx_s at center-1/center/center+1, decided at center+1 (all
// later timing moves one cycle later). Undefined: single sample at center.
//
// Ports:
//   Clk         system clock (50 MHz)
//   Rst         synchronous active-high reset
//   Baud_sel    0:9600 1:19200 2:38400 3:57600 4:115200, 5-7 -> 9600;
//               latched at the start edge of each frame
//   Uart_rx     asynchronous serial input
//   Data_byte   last correctly received byte, held until the next good frame
//   Rx_done     one-cycle pulse, Data_byte valid in the same cycle
//   Frame_err   one-cycle pulse when the stop bit samples low
//   Uart_state  1 while a frame is in progress (START..STOP)
// -----------------------------------------------------------------------------
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BIT_CNT_W   = 13
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [2:0] Baud_sel,
  input  logic       Uart_rx,
  output logic [7:0] Data_byte,
  output logic       Rx_done,
  output logic       Frame_err,
  output logic       Uart_state
);

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_OFF = 1;
`else
  localparam int SAMPLE_OFF = 0;
`endif

  logic rx_s;
  logic rx_fall;

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (Clk),
    .rst_i  (Rst),
    .rx_i   (Uart_rx),
    .rx_s_o (rx_s),
    .fall_o (rx_fall)
  );

  uart_state_e          state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0] baud_end_q, baud_end_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;

  logic                 sample_bit;
  logic [BIT_CNT_W-1:0] start_pt;

`ifdef UART_RX_MAJORITY_EN
  // Two-deep history of rx_s; at decision time rx_s is the center+1 sample,
  // hist_q[0] the center sample and hist_q[1] the center-1 sample.
  logic [1:0] hist_q;

  always_ff @(posedge Clk) begin
    if (Rst) hist_q <= 2'b11;
    else     hist_q <= {hist_q[0], rx_s};
  end

  assign sample_bit = maj3_f(rx_s, hist_q[0], hist_q[1]);
`else
  assign sample_bit = rx_s;
`endif

  // Start-bit decision point; data/stop decisions follow at whole periods.
  assign start_pt = (baud_end_q >> 1) + BIT_CNT_W'(SAMPLE_OFF);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    baud_end_d = baud_end_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_fall) begin
          state_d    = ST_START;
          baud_end_d = BIT_CNT_W'(baud_end_f(Baud_sel));
        end
      end

      ST_START: begin
        cnt_d = cnt_q + BIT_CNT_W'(1);
        if (cnt_q == start_pt) begin
          if (sample_bit) begin
            // Line back high at mid start bit: noise, drop silently.
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d   = ST_DATA;
            cnt_d     = '0;
            bit_idx_d = 3'd0;
          end
        end
      end

      ST_DATA: begin
        if (cnt_q == baud_end_q) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = sample_bit;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + BIT_CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == baud_end_q) begin
          cnt_d = '0;
          if (sample_bit) begin
            // Back to IDLE at stop-bit center so a following start edge
            // half a bit later is still caught.
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + BIT_CNT_W'(1);
        end
      end

      ST_BREAK: begin
        // Line held low after a framing error: wait for idle before re-arming.
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      baud_end_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      baud_end_q <= baud_end_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign Data_byte  = data_q;
  assign Rx_done    = done_q;
  assign Frame_err  = ferr_q;
  assign Uart_state = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte
// Directed bench for uart_rx_byte: a table of good frames plus hand-written
// sequences for start glitch, framing error with held-low line, mid-frame
// reset, mid-frame Baud_sel change and per-bit center glitches.
// -----------------------------------------------------------------------------
module tb_uart_rx_byte;

  localparam int SYNC_STAGES = 2;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [2:0] Baud_sel;
  logic       Uart_rx;
  logic [7:0] Data_byte;
  logic       Rx_done;
  logic       Frame_err;
  logic       Uart_state;

  uart_rx_byte #(.SYNC_STAGES(SYNC_STAGES), .BIT_CNT_W(13)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Baud_sel   (Baud_sel),
    .Uart_rx    (Uart_rx),
    .Data_byte  (Data_byte),
    .Rx_done    (Rx_done),
    .Frame_err  (Frame_err),
    .Uart_state (Uart_state)
  );

  always #10 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Cycle counter and output-pulse monitor (sampled on the falling edge).
  int pcyc      = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  int done_pcyc = 0;

  always @(posedge Clk) pcyc <= pcyc + 1;

  always @(negedge Clk) begin
    if (Rx_done) begin
      done_cnt  <= done_cnt + 1;
      done_pcyc <= pcyc;
    end
    if (Frame_err)            err_cnt  <= err_cnt + 1;
    if (Rx_done && Frame_err) both_cnt <= both_cnt + 1;
  end

  function automatic int bend(input logic [2:0] s);
    case (s)
      3'd0:    return 5207;
      3'd1:    return 2603;
      3'd2:    return 1301;
      3'd3:    return 867;
      3'd4:    return 433;
      default: return 5207;
    endcase
  endfunction

  // Expected Rx_done latency (cycles from the first low start-bit cycle).
  function automatic int exp_lat(input logic [2:0] s);
    return SYNC_STAGES + (bend(s) >> 1) + 1 + 9 * (bend(s) + 1) + 1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_lat(input string nm, input int act, input int exp);
    tests++;
    if (act < exp - 1 || act > exp + 1) begin
      fails++;
      $display("FAIL %s: latency %0d cycles, expected %0d +/-1", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      Uart_rx = 1'b1;
    end
  endtask

  task automatic hold(input logic v, input int n);
    repeat (n) begin
      @(negedge Clk);
      Uart_rx = v;
    end
  endtask

  // Drive one 8N1 frame timed for baud code tsel.
  //  goff  >= 0 : invert Uart_rx for the single cycle at offset goff of each
  //               data bit.
  //  chg_b >= 0 : set Baud_sel=chg_sel halfway through frame bit chg_b
  //               (0=start, 1..8=data, 9=stop).
  //  st         : posedge count just before the first start-bit cycle.
  task automatic send_frame(input logic [2:0] tsel, input logic [7:0] d,
                            input logic stopb, input int goff,
                            input int chg_b, input logic [2:0] chg_sel,
                            output int st);
    int         t;
    logic [9:0] bits;
    t    = bend(tsel) + 1;
    bits = {stopb, d, 1'b0};
    st   = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < t; c++) begin
        @(negedge Clk);
        if (b == 0 && c == 0) st = pcyc;
        if (b == chg_b && c == t / 2) Baud_sel = chg_sel;
        if (goff >= 0 && b >= 1 && b <= 8 && c == goff) Uart_rx = ~bits[b];
        else                                            Uart_rx = bits[b];
      end
    end
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    int         gap;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int st, d0, e0;
    logic [7:0] exp_glitch;

    vecs[0] = '{3'd4, 8'h55, 20, 8'h55};
    vecs[1] = '{3'd4, 8'hA3, 0,  8'hA3};   // back-to-back with the previous frame
    vecs[2] = '{3'd4, 8'h00, 30, 8'h00};

    Rst      = 1'b1;
    Uart_rx  = 1'b1;
    Baud_sel = 3'd4;
    repeat (3) @(negedge Clk);
    chk("reset_data", Data_byte, 8'h00);
    chk("reset_flags", {Rx_done, Frame_err, Uart_state}, 3'b000);
    Rst = 1'b0;

    // ---- good frames from the table ----
    for (int i = 0; i < 3; i++) begin
      Baud_sel = vecs[i].sel;
      idle(vecs[i].gap);
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].sel, vecs[i].data, 1'b1, -1, -1, 3'd0, st);
      chk($sformatf("vec%0d_done", i), done_cnt - d0, 1);
      chk($sformatf("vec%0d_ferr", i), err_cnt - e0, 0);
      chk($sformatf("vec%0d_byte", i), Data_byte, vecs[i].exp_byte);
      chk_lat($sformatf("vec%0d_lat", i), done_pcyc - st, exp_lat(vecs[i].sel));
    end

    // ---- Baud_sel 4 -> 0 during data bit 2: frame stays at 115200 ----
    Baud_sel = 3'd4;
    idle(20);
    d0 = done_cnt;
    send_frame(3'd4, 8'h96, 1'b1, -1, 3, 3'd0, st);
    chk("chg_done", done_cnt - d0, 1);
    chk("chg_byte", Data_byte, 8'h96);
    chk_lat("chg_lat", done_pcyc - st, exp_lat(3'd4));

    // ---- 1000-cycle low pulse at 9600 (the latched rate now): glitch ----
    idle(20);
    d0 = done_cnt;
    e0 = err_cnt;
    hold(1'b0, 1000);
    chk("glitch_busy", Uart_state, 1);
    hold(1'b1, 2000);
    chk("glitch_idle", Uart_state, 0);
    chk("glitch_done", done_cnt - d0, 0);
    chk("glitch_ferr", err_cnt - e0, 0);
    Baud_sel = 3'd4;
    idle(20);
    send_frame(3'd4, 8'h0F, 1'b1, -1, -1, 3'd0, st);
    chk("post_glitch_done", done_cnt - d0, 1);
    chk("post_glitch_byte", Data_byte, 8'h0F);

    // ---- framing error at 38400, then line held low 3 bit times ----
    Baud_sel = 3'd2;
    idle(20);
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(3'd2, 8'hFF, 1'b0, -1, -1, 3'd0, st);
    hold(1'b0, 3 * (bend(3'd2) + 1));
    chk("ferr_pulse", err_cnt - e0, 1);
    chk("ferr_no_done", done_cnt - d0, 0);
    chk("ferr_hold_byte", Data_byte, 8'h0F);
    chk("ferr_no_rearm", Uart_state, 0);
    idle(20);
    Baud_sel = 3'd4;
    idle(10);
    send_frame(3'd4, 8'h81, 1'b1, -1, -1, 3'd0, st);
    chk("post_ferr_done", done_cnt - d0, 1);
    chk("post_ferr_byte", Data_byte, 8'h81);
    chk("post_ferr_err", err_cnt - e0, 1);

    // ---- reset pulse during data bit 4 of 0xF0 at 19200 ----
    Baud_sel = 3'd1;
    idle(20);
    d0 = done_cnt;
    e0 = err_cnt;
    hold(1'b0, 5 * (bend(3'd1) + 1));      // start + data bits 0..3 (all 0)
    hold(1'b1, (bend(3'd1) + 1) / 2);      // into data bit 4 (1)
    chk("rst_mid_busy", Uart_state, 1);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("rst_mid_data", Data_byte, 8'h00);
    chk("rst_mid_flags", {Rx_done, Frame_err, Uart_state}, 3'b000);
    idle(2000);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_no_ferr", err_cnt - e0, 0);
    Baud_sel = 3'd4;
    idle(10);
    send_frame(3'd4, 8'h3C, 1'b1, -1, -1, 3'd0, st);
    chk("post_rst_done", done_cnt - d0, 1);
    chk("post_rst_byte", Data_byte, 8'h3C);

    // ---- one-cycle inverted glitch on the Uart_rx cycle that lands on each
    //      data-bit center sample (offset center+1 within the bit, the extra
    //      cycle being the synchronizer/edge pipeline) ----
`ifdef UART_RX_MAJORITY_EN
    exp_glitch = 8'h5A;
`else
    exp_glitch = 8'hA5;
`endif
    idle(20);
    d0 = done_cnt;
    send_frame(3'd4, 8'h5A, 1'b1, (bend(3'd4) >> 1) + 1, -1, 3'd0, st);
    chk("center_glitch_done", done_cnt - d0, 1);
    chk("center_glitch_byte", Data_byte, exp_glitch);

    idle(10);
    chk("never_both", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART byte receiver; the receive-side counterpart of uart_tx_byte on the same serial link.
- Frame format: 8N1, LSB first, idle-high line.
- Shares the Baud_sel encoding and 50 MHz (20 ns) clock with the transmitter.
- Delivers each received byte with a one-cycle done strobe and flags framing errors; sits between the board RX pin and byte-level consumers (FIFO, command parser).

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the Uart_rx input synchronizer (minimum 2).
- BIT_CNT_W, 13, width of the bit-period counter; must hold 5207.

Ports:
- Clk  input  1  system clock, 50 MHz.
- Rst  input  1  synchronous, active-high reset.
- Baud_sel  input  3  0:9600 1:19200 2:38400 3:57600 4:115200; 5-7 map to 9600.
- Uart_rx  input  1  asynchronous serial input, idle high.
- Data_byte  output  8  last correctly received byte; holds until the next good frame.
- Rx_done  output  1  one-cycle pulse; Data_byte is valid in the same cycle.
- Frame_err  output  1  one-cycle pulse when the stop bit samples low.
- Uart_state  output  1  1 while a frame is in progress (START through STOP).

Behaviour:
- Reset (Rst=1 at a Clk edge): Data_byte=0, Rx_done=0, Frame_err=0, Uart_state=0, FSM=IDLE, synchronizer flops=1, counters=0.
- Bit period end value BAUD_END by Baud_sel: 5207, 2603, 1301, 867, 433. Bit period = BAUD_END+1 cycles. Center = BAUD_END>>1.
- Baud_sel is sampled into an internal register on the IDLE->START transition. Changes mid-frame are ignored until the next frame.
- rx_s is Uart_rx after SYNC_STAGES flops. A falling edge is rx_s_prev=1 and rx_s=0.
- FSM states:
  - IDLE: on a falling edge, go to START; clear cnt; Uart_state=1.
  - START: cnt counts up. At cnt==center, sample rx_s. If 1 (glitch), go to IDLE with no pulses. If 0, clear cnt and go to DATA with bit_idx=0.
  - DATA: cnt counts 0..BAUD_END and wraps to 0. At each wrap (one full period after the previous center), shift the sample into shift[bit_idx], LSB first. After bit_idx 7 is sampled, go to STOP.
  - STOP: sample one full period after the bit-7 sample.
    - Sample 1: Data_byte<=shift and Rx_done=1 on the next cycle; go to IDLE.
    - Sample 0: Frame_err=1 on the next cycle; Data_byte is unchanged; go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. No rearm occurs while the line is held low.
- Uart_state drops to 0 in the same cycle Rx_done or Frame_err pulses, or on a glitch abort.
- Latency: Rx_done rises SYNC_STAGES + (center+1) + 9*(BAUD_END+1) + 1 cycles after the Uart_rx falling edge, ±1.
- Back-to-back frames: IDLE is re-entered at the stop-bit center, so a start edge arriving half a bit later is caught.
- Rx_done and Frame_err are never high together.
- Rst mid-frame aborts immediately. No pulse is emitted and the partial byte is discarded.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each sample (start, data, stop) is the 2-of-3 majority of rx_s at center-1, center and center+1. The decision is taken at center+1, so all subsequent timing shifts by +1 cycle.
- Undefined: single sample at center.
- Ports are identical in both builds.

Decomposition:
- Shared package/header uart_pkg (shared with uart_tx_byte):
  - BAUD_END constants per Baud_sel code.
  - Baud_sel code localparams.
  - FSM state encodings for IDLE, START, DATA, STOP, BREAK.
- Natural sub-module: uart_sync. It is a SYNC_STAGES-deep synchronizer plus falling-edge detector and is reusable by other RX-side blocks. The FSM, counter and shifter stay in uart_rx_byte.

Test Plan:
- Baud_sel=4, send 0x55 then 0xA3 back-to-back with 8N1 bit time 434 cycles -> two Rx_done pulses; Data_byte=0x55 then 0xA3; Frame_err never asserted.
- Baud_sel=0, Uart_rx low for 1000 cycles then high (below center 2603) -> no Rx_done or Frame_err; Uart_state returns to 0; a following valid 0x0F is received correctly.
- Baud_sel=2, send 0xFF with stop bit 0, then hold the line low for 3 bit times -> single Frame_err pulse; Data_byte keeps its prior value; no new frame starts until the line goes high; the next 0x81 is received.
- Assert Rst for 1 cycle during bit 4 of a frame at Baud_sel=1 -> all outputs 0 the next cycle; no pulse; the next full frame 0x3C is received.
- Change Baud_sel from 4 to 0 during bit 2 of a 115200 frame 0x96 -> byte received as 0x96 at 115200; the next frame uses 9600.
- UART_RX_MAJORITY_EN defined: 1-cycle inverted glitch exactly at the center of each data bit of 0x5A -> Data_byte=0x5A. Same glitch with the macro undefined -> Data_byte=0xA5.
